// File: rtl/axis_ic_pkg.sv
// Shared types and helpers for the AXI4-Stream interconnect arbiters and buffers.
package axis_ic_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // ENTRY_PACKET field order, MSB to LSB: tdata, tdest, tid, tuser, tlast.
  typedef enum logic [2:0] {
    ENTRY_TDATA = 3'd0,
    ENTRY_TDEST = 3'd1,
    ENTRY_TID   = 3'd2,
    ENTRY_TUSER = 3'd3,
    ENTRY_TLAST = 3'd4
  } entry_field_e;

  function automatic int entry_width(input int data_bytes, input int dest_w,
                                     input int id_w, input int user_w);
    return data_bytes * 8 + dest_w + id_w + user_w + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester above the last grant, with wraparound.
module rr_picker #(
  parameter int S    = 4,
  parameter int IDXW = (S > 1) ? $clog2(S) : 1
) (
  input  logic [S-1:0]    req,
  input  logic [IDXW-1:0] last,
  output logic [IDXW-1:0] gnt_idx,
  output logic            any
);

  logic [IDXW-1:0] cand_s;
  logic            found_s;

  // Scan (last+1) .. (last+S) mod S and keep the first hit.
  always_comb begin
    gnt_idx = '0;
    cand_s  = '0;
    found_s = 1'b0;
    for (int i = 1; i <= S; i++) begin
      cand_s = IDXW'((int'(last) + i) % S);
      if (!found_s && req[cand_s]) begin
        gnt_idx = cand_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-atomic round-robin arbiter: locks one AXI4-Stream input from first beat to
// tlast and drives a registered output beat.
module axis_packet_arbiter
  import axis_ic_pkg::*;
#(
  parameter int S           = 4,
  parameter int DATA_WIDTH  = 2,
  parameter int TDEST_WIDTH = 4,
  parameter int TID_WIDTH   = 2,
  parameter int TUSER_WIDTH = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [S-1:0][DATA_WIDTH*8-1:0]      s_axis_tdata,
  input  logic [S-1:0][TDEST_WIDTH-1:0]       s_axis_tdest,
  input  logic [S-1:0][TID_WIDTH-1:0]         s_axis_tid,
  input  logic [S-1:0][TUSER_WIDTH-1:0]       s_axis_tuser,
  input  logic [S-1:0]                        s_axis_tvalid,
  input  logic [S-1:0]                        s_axis_tlast,
  output logic [S-1:0]                        s_axis_tready,
  output logic [DATA_WIDTH*8-1:0]             m_axis_tdata,
  output logic [TDEST_WIDTH-1:0]              m_axis_tdest,
  output logic [TID_WIDTH-1:0]                m_axis_tid,
  output logic [TUSER_WIDTH-1:0]              m_axis_tuser,
  output logic                                m_axis_tlast,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [S-1:0]                        arb_grant,
  output logic                                arb_busy
);

  localparam int IDXW     = (S > 1) ? $clog2(S) : 1;
  localparam int BEAT_W   = entry_width(DATA_WIDTH, TDEST_WIDTH, TID_WIDTH, TUSER_WIDTH);
  localparam int OFF_USER = 1;
  localparam int OFF_ID   = OFF_USER + TUSER_WIDTH;
  localparam int OFF_DEST = OFF_ID + TID_WIDTH;
  localparam int OFF_DATA = OFF_DEST + TDEST_WIDTH;

  arb_state_e        state_r, state_nxt_s;
  logic [IDXW-1:0]   rr_last_r, grant_idx_r, pick_idx_s;
  logic [S-1:0]      grant_r, pick_oh_s, tready_s;
  logic              pick_any_s, out_ready_s, accept_s, pkt_end_s;
  logic [BEAT_W-1:0] beat_s, beat_r;
  logic              m_valid_r;

  rr_picker #(.S(S)) u_picker (
    .req     (s_axis_tvalid),
    .last    (rr_last_r),
    .gnt_idx (pick_idx_s),
    .any     (pick_any_s)
  );

  assign out_ready_s = !m_valid_r || m_axis_tready;
  assign beat_s = {s_axis_tdata[grant_idx_r], s_axis_tdest[grant_idx_r], s_axis_tid[grant_idx_r],
                   s_axis_tuser[grant_idx_r], s_axis_tlast[grant_idx_r]};

  // Next state, owner handshake and one-hot form of the picker result.
  always_comb begin
    state_nxt_s = state_r;
    tready_s    = '0;
    accept_s    = 1'b0;
    pkt_end_s   = 1'b0;
    pick_oh_s   = '0;
    pick_oh_s[pick_idx_s] = 1'b1;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_nxt_s = LOCKED;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCKED: begin
        tready_s[grant_idx_r] = out_ready_s;
        accept_s  = s_axis_tvalid[grant_idx_r] && out_ready_s;
        pkt_end_s = accept_s && s_axis_tlast[grant_idx_r];
        if (pkt_end_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Arbitration state: lock on grant in IDLE, release and remember owner on tlast.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      rr_last_r   <= IDXW'(S - 1);
      grant_idx_r <= '0;
      grant_r     <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == IDLE && pick_any_s) begin
        grant_idx_r <= pick_idx_s;
        grant_r     <= pick_oh_s;
      end
      if (pkt_end_s) begin
        rr_last_r <= grant_idx_r;
        grant_r   <= '0;
      end
    end
  end

  // Output register; payload holds while stalled or empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_r <= 1'b0;
      beat_r    <= '0;
    end else if (accept_s) begin
      m_valid_r <= 1'b1;
      beat_r    <= beat_s;
    end else if (m_axis_tready) begin
      m_valid_r <= 1'b0;
    end
  end

  assign s_axis_tready = tready_s;
  assign m_axis_tvalid = m_valid_r;
  assign m_axis_tlast  = beat_r[0];
  assign m_axis_tuser  = beat_r[OFF_USER +: TUSER_WIDTH];
  assign m_axis_tid    = beat_r[OFF_ID +: TID_WIDTH];
  assign m_axis_tdest  = beat_r[OFF_DEST +: TDEST_WIDTH];
  assign m_axis_tdata  = beat_r[OFF_DATA +: DATA_WIDTH*8];
  assign arb_grant     = grant_r;
  assign arb_busy      = (state_r == LOCKED);

endmodule
